// File: rtl/spi_flash_erase_ctrl.sv
// SPI-flash erase engine.
// A start pulse runs WREN, then a bulk / 64 KB sector / 4 KB subsector erase,
// then (optionally) polls RDSR until WIP clears or the poll budget runs out.
// SPI mode 0, MSB first. cs_n, sck and mosi are registered, so the counters
// always describe the SPI cycle currently on the pins.
module spi_flash_erase_ctrl #(
  parameter int          SCK_DIV   = 4,
  parameter int          CS_GAP    = 8,
  parameter bit          POLL_EN   = 1'b1,
  parameter logic [15:0] MAX_POLLS = 16'd50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [23:0] addr,
  input  logic        miso,
  output logic        cs_n,
  output logic        sck,
  output logic        mosi,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int H     = SCK_DIV / 2;
  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int GAP_W = $clog2(CS_GAP + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE  = DIV_W'(H);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(H - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_GAP - 1);

  // FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WREN  = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_ERASE = 3'd3;
  localparam logic [2:0] ST_POLL  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Segments of one cs_n-low frame: lead-in half period, data bits, tail half period
  localparam logic [1:0] SEG_LEAD  = 2'd0;
  localparam logic [1:0] SEG_BITS  = 2'd1;
  localparam logic [1:0] SEG_TRAIL = 2'd2;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_BULK = 8'hC7;
  localparam logic [7:0] OP_SECT = 8'hD8;
  localparam logic [7:0] OP_SUB  = 8'h20;

  localparam logic [1:0] MODE_RSVD = 2'b11;

  // Control state
  logic [2:0]       state, state_nxt;
  logic [1:0]       seg, seg_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [5:0]       bit_cnt, bit_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [15:0]      poll_cnt, poll_nxt, poll_inc;
  logic             gap_to_erase, gap_to_erase_nxt;
  logic             err_nxt;

  // Datapath state (never reset: always reloaded before use)
  logic [1:0]  mode_q;
  logic [23:0] addr_q;
  logic [31:0] tx_sr, tx_nxt;
  logic        wip_q, wip_nxt;

  logic [5:0] last_bit;
  logic       frame_end;
  logic       frame_nxt;

  function automatic logic [7:0] erase_opcode(input logic [1:0] m);
    case (m)
      2'b00:   return OP_BULK;
      2'b01:   return OP_SECT;
      default: return OP_SUB;
    endcase
  endfunction

  // Index of the final bit of the frame issued in state st
  function automatic logic [5:0] frame_last_bit(input logic [2:0] st, input logic [1:0] m);
    case (st)
      ST_WREN:  return 6'd7;
      ST_ERASE: return (m == 2'b00) ? 6'd7 : 6'd31;
      ST_POLL:  return 6'd15;
      default:  return 6'd0;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign last_bit  = frame_last_bit(state, mode_q);
  assign poll_inc  = sat_inc16(poll_cnt);
  assign frame_nxt = (state_nxt == ST_WREN) || (state_nxt == ST_ERASE) ||
                     (state_nxt == ST_POLL);

  // Next-state: FSM sequencing plus the per-frame divider / bit stepping
  always_comb begin
    state_nxt        = state;
    seg_nxt          = seg;
    div_nxt          = div;
    bit_nxt          = bit_cnt;
    gap_nxt          = gap_cnt;
    poll_nxt         = poll_cnt;
    gap_to_erase_nxt = gap_to_erase;
    tx_nxt           = tx_sr;
    wip_nxt          = wip_q;
    err_nxt          = err;
    frame_end        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          poll_nxt = 16'd0;
          if (mode == MODE_RSVD) begin
            state_nxt = ST_DONE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ST_WREN;
            err_nxt   = 1'b0;
            seg_nxt   = SEG_LEAD;
            div_nxt   = '0;
            bit_nxt   = 6'd0;
            tx_nxt    = {OP_WREN, 24'h0};
          end
        end
      end

      ST_WREN, ST_ERASE, ST_POLL: begin
        case (seg)
          SEG_LEAD: begin
            if (div == HALF_LAST) begin
              seg_nxt = SEG_BITS;
              div_nxt = '0;
            end else begin
              div_nxt = div + DIV_W'(1);
            end
          end
          SEG_BITS: begin
            // miso is taken in the cycle where sck is first high
            if (div == DIV_RISE) wip_nxt = miso;
            if (div == DIV_LAST) begin
              div_nxt = '0;
              tx_nxt  = {tx_sr[30:0], 1'b0};
              if (bit_cnt == last_bit) seg_nxt = SEG_TRAIL;
              else                     bit_nxt = bit_cnt + 6'd1;
            end else begin
              div_nxt = div + DIV_W'(1);
            end
          end
          default: begin
            if (div == HALF_LAST) frame_end = 1'b1;
            else                  div_nxt   = div + DIV_W'(1);
          end
        endcase

        if (frame_end) begin
          case (state)
            ST_WREN: begin
              state_nxt        = ST_GAP;
              gap_nxt          = '0;
              gap_to_erase_nxt = 1'b1;
            end
            ST_ERASE: begin
              if (POLL_EN) begin
                state_nxt        = ST_GAP;
                gap_nxt          = '0;
                gap_to_erase_nxt = 1'b0;
              end else begin
                state_nxt = ST_DONE;
              end
            end
            default: begin
              // Last bit shifted in is status[0] = WIP
              poll_nxt = poll_inc;
              if (!wip_q) begin
                state_nxt = ST_DONE;
              end else if (poll_inc >= MAX_POLLS) begin
                state_nxt = ST_DONE;
                err_nxt   = 1'b1;
              end else begin
                state_nxt        = ST_GAP;
                gap_nxt          = '0;
                gap_to_erase_nxt = 1'b0;
              end
            end
          endcase
        end
      end

      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = gap_to_erase ? ST_ERASE : ST_POLL;
          seg_nxt   = SEG_LEAD;
          div_nxt   = '0;
          bit_nxt   = 6'd0;
          tx_nxt    = gap_to_erase ? {erase_opcode(mode_q), addr_q} : {OP_RDSR, 24'h0};
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end

      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control registers and registered pin drivers (decoded from next state)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      seg          <= SEG_LEAD;
      div          <= '0;
      bit_cnt      <= 6'd0;
      gap_cnt      <= '0;
      poll_cnt     <= 16'd0;
      gap_to_erase <= 1'b0;
      cs_n         <= 1'b1;
      sck          <= 1'b0;
      mosi         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      seg          <= seg_nxt;
      div          <= div_nxt;
      bit_cnt      <= bit_nxt;
      gap_cnt      <= gap_nxt;
      poll_cnt     <= poll_nxt;
      gap_to_erase <= gap_to_erase_nxt;
      cs_n         <= !frame_nxt;
      sck          <= frame_nxt && (seg_nxt == SEG_BITS) && (div_nxt >= DIV_RISE);
      mosi         <= frame_nxt && (seg_nxt == SEG_BITS) && tx_nxt[31];
      busy         <= (state_nxt != ST_IDLE);
      done         <= (state_nxt == ST_DONE);
      err          <= err_nxt;
    end
  end

  // Request latch and shift registers
  always_ff @(posedge sys_clk) begin
    if ((state == ST_IDLE) && start) begin
      mode_q <= mode;
      addr_q <= addr;
    end
    tx_sr <= tx_nxt;
    wip_q <= wip_nxt;
  end

endmodule

// File: tb/tb_spi_flash_erase_ctrl.sv
// Bench for spi_flash_erase_ctrl: table of erase requests plus hand-written
// reset and start-filtering sequences. A small flash model answers RDSR.
`timescale 1ns/1ps
module tb_spi_flash_erase_ctrl;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        start     = 1'b0;
  logic [1:0]  mode      = 2'b00;
  logic [23:0] addr      = 24'h0;
  logic        miso      = 1'b0;
  logic        cs_n, sck, mosi, busy, done, err;

  spi_flash_erase_ctrl #(
    .SCK_DIV  (4),
    .CS_GAP   (8),
    .POLL_EN  (1'b1),
    .MAX_POLLS(16'd4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .mode     (mode),
    .addr     (addr),
    .miso     (miso),
    .cs_n     (cs_n),
    .sck      (sck),
    .mosi     (mosi),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor + flash model ----------------
  logic [31:0] f_data [128];
  int          f_bits [128];
  int          f_len  [128];
  int          f_gap  [128];
  int          n_frames   = 0;
  int          n_rdsr     = 0;
  int          idle_viol  = 0;
  int          wip_base   = 0;
  int          wip_ones   = 0;

  logic        in_frame = 1'b0;
  logic        prev_sck = 1'b0;
  int          cur_len, cur_bits, cur_gap, hi_cnt = 0;
  logic [31:0] cur_data;
  logic [7:0]  cur_op;
  logic [7:0]  sb;

  always @(negedge sys_clk) begin
    if (!cs_n) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        cur_len  = 0;
        cur_bits = 0;
        cur_data = 32'h0;
        cur_op   = 8'h0;
        cur_gap  = hi_cnt;
      end
      cur_len++;
      if (sck && !prev_sck) begin
        cur_data = {cur_data[30:0], mosi};
        cur_bits++;
        if (cur_bits == 8) cur_op = cur_data[7:0];
      end
      if (!sck && prev_sck) begin
        // status = SRWD=1, WEL=1, WIP from the scripted sequence
        sb = {1'b1, 5'b00000, 1'b1, ((n_rdsr - wip_base) < wip_ones)};
        if (cur_op == 8'h05 && cur_bits >= 8 && cur_bits < 16) miso = sb[15 - cur_bits];
        else                                                    miso = 1'b0;
      end
    end else begin
      if (in_frame) begin
        if (n_frames < 128) begin
          f_data[n_frames] = cur_data;
          f_bits[n_frames] = cur_bits;
          f_len[n_frames]  = cur_len;
          f_gap[n_frames]  = cur_gap;
        end
        n_frames++;
        if (cur_op == 8'h05) n_rdsr++;
        in_frame = 1'b0;
        hi_cnt   = 0;
      end
      hi_cnt++;
      miso = 1'b0;
      if (mosi || sck) idle_viol++;
    end
    prev_sck = sck;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  mode;
    logic [23:0] addr;
    int          wip_ones;
    int          inj_cyc;
    bit          start_at_done;
    int          exp_frames;
    logic [31:0] exp_word;
    int          exp_bits;
    int          exp_len;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];
  logic prev_err = 1'b0;

  task automatic run_vec(input int idx, input vec_t v);
    int   cyc;
    int   base;
    int   nf;
    logic ok;
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge sys_clk);
    chk({p, " err_held"}, err, prev_err);
    chk({p, " idle_busy"}, busy, 1'b0);
    base     = n_frames;
    wip_base = n_rdsr;
    wip_ones = v.wip_ones;
    start = 1'b1;
    mode  = v.mode;
    addr  = v.addr;
    @(negedge sys_clk);
    start = 1'b0;
    cyc   = 1;
    chk({p, " busy_c1"}, busy, 1'b1);
    chk({p, " err_c1"}, err, (v.mode == 2'b11));
    while (!done && cyc < 3000) begin
      if (cyc == v.inj_cyc) begin
        start = 1'b1;
        mode  = (v.mode == 2'b01) ? 2'b10 : 2'b01;
        addr  = ~v.addr;
      end else begin
        start = 1'b0;
      end
      @(negedge sys_clk);
      cyc++;
    end
    start = 1'b0;
    chk({p, " done_seen"}, done, 1'b1);
    chk({p, " done_cyc"}, cyc, v.exp_done);
    chk({p, " err_done"}, err, v.exp_err);
    if (v.start_at_done) start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk({p, " done_pulse_end"}, {done, busy}, 2'b00);
    ok = 1'b1;
    repeat (4) begin
      @(negedge sys_clk);
      if (busy || !cs_n) ok = 1'b0;
    end
    if (v.start_at_done) chk({p, " start_at_done_ignored"}, ok, 1'b1);
    chk({p, " err_hold"}, err, v.exp_err);
    nf = n_frames - base;
    chk({p, " frames"}, nf, v.exp_frames);
    if (nf >= v.exp_frames && v.exp_frames >= 2) begin
      chk({p, " wren_data"}, f_data[base], 32'h06);
      chk({p, " wren_bits"}, f_bits[base], 8);
      chk({p, " wren_len"}, f_len[base], 36);
      chk({p, " erase_data"}, f_data[base+1], v.exp_word);
      chk({p, " erase_bits"}, f_bits[base+1], v.exp_bits);
      chk({p, " erase_len"}, f_len[base+1], v.exp_len);
      for (int k = 2; k < v.exp_frames; k++) begin
        chk($sformatf("%s rdsr%0d_data", p, k), f_data[base+k], 32'h0500);
        chk($sformatf("%s rdsr%0d_len", p, k), f_len[base+k], 68);
      end
      for (int k = 1; k < v.exp_frames; k++)
        chk($sformatf("%s gap%0d", p, k), f_gap[base+k], 8);
    end
    prev_err = v.exp_err;
  endtask

  initial begin
    //        mode   addr         wip inj sad frm word          bits len  done err
    vecs[0] = '{2'b00, 24'h000000,   2,   0, 0, 5, 32'h000000C7,  8,  36, 309, 1'b0};
    vecs[1] = '{2'b01, 24'h123456,   0,   0, 0, 3, 32'hD8123456, 32, 132, 253, 1'b0};
    vecs[2] = '{2'b10, 24'h123456,   1,   0, 0, 4, 32'h20123456, 32, 132, 329, 1'b0};
    vecs[3] = '{2'b00, 24'h000000, 100,   0, 0, 6, 32'h000000C7,  8,  36, 385, 1'b1};
    vecs[4] = '{2'b01, 24'hABCDEF,   0,   0, 0, 3, 32'hD8ABCDEF, 32, 132, 253, 1'b0};
    vecs[5] = '{2'b11, 24'h000000,   0,   0, 0, 0, 32'h00000000,  0,   0,   1, 1'b1};
    vecs[6] = '{2'b00, 24'h000000,   0,  60, 1, 3, 32'h000000C7,  8,  36, 157, 1'b0};
    vecs[7] = '{2'b10, 24'hFEDCBA,   0, 100, 0, 3, 32'h20FEDCBA, 32, 132, 253, 1'b0};

    #2 sys_rst_n = 1'b0;
    #1 chk("reset_outputs", {cs_n, sck, mosi, busy, done, err}, 6'b100000);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a sector-erase frame
    @(negedge sys_clk);
    start = 1'b1;
    mode  = 2'b01;
    addr  = 24'h111111;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (99) @(negedge sys_clk);
    chk("rst_mid_frame_active", cs_n, 1'b0);
    #2 sys_rst_n = 1'b0;
    #1 chk("rst_async_outputs", {cs_n, sck, mosi, busy, done, err}, 6'b100000);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("rst_released_idle", {cs_n, sck, mosi, busy, done, err}, 6'b100000);
    prev_err = 1'b0;
    run_vec(8, vecs[1]);

    chk("idle_pins_quiet", idle_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
